// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store/LL/SC access unit driving a req/gnt/ack data bus.
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter bit BIG_ENDIAN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [7:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              llclr_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              buserr_o,
  output logic              llbit_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LWL_OP = 8'b11100010;
  localparam logic [7:0] EXE_LWR_OP = 8'b11100110;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [7:0] EXE_SWL_OP = 8'b11101010;
  localparam logic [7:0] EXE_SWR_OP = 8'b11101110;
  localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
  localparam logic [7:0] EXE_SC_OP  = 8'b11111000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam bit              TMO_EN   = (TIMEOUT_CYC != 0);

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP, EXE_SC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP, EXE_LL_OP, EXE_SC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // LWL/LWR/SWL/SWR are never misaligned by construction.
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           return a[0];
      EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: return a != 2'b00;
      default:                                    return 1'b0;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adel_q, adel_d, ades_q, ades_d, berr_q, berr_d;
  logic              scfail_q, scfail_d, flushed_q, flushed_d, llbit_q, llbit_d;

  logic              acc_mis, acc_scfail, tmo_hit, exc_any, in_req;
  logic [1:0]        lane, hlane;
  logic [4:0]        sh_l, sh_r;
  logic [3:0]        be;
  logic [31:0]       wd, res;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign acc_mis    = misaligned(op_i, addr_i[1:0]);
  assign acc_scfail = (op_i == EXE_SC_OP) && !llbit_q;
  assign tmo_hit    = TMO_EN && (cnt_q == CNT_LAST);
  assign exc_any    = adel_q | ades_q | berr_q;
  assign in_req     = (state_q == S_REQ);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    adel_d    = adel_q;
    ades_d    = ades_q;
    berr_d    = berr_q;
    scfail_d  = scfail_q;
    flushed_d = flushed_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_i && !flush_i) begin
          op_d      = op_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          word_d    = '0;
          flushed_d = 1'b0;
          berr_d    = 1'b0;
          adel_d    = acc_mis && !is_store(op_i);
          ades_d    = acc_mis && is_store(op_i);
          scfail_d  = acc_scfail;
          state_d   = (acc_mis || acc_scfail || !is_known(op_i)) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          state_d   = S_WAIT;
          cnt_d     = '0;
          flushed_d = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          berr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A flushed access must still see its ack before the bus is free.
        flushed_d = flushed_q | flush_i;
        if (bus_ack_i) begin
          word_d  = bus_rdata_i;
          state_d = (flushed_q || flush_i) ? S_IDLE : S_DONE;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = (flushed_q || flush_i) ? S_IDLE : S_DONE;
          berr_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lane  = addr_q[1:0] ^ {2{BIG_ENDIAN}};
  assign hlane = {lane[1], 1'b0};
  assign sh_l  = {lane, 3'b000};
  assign sh_r  = {~lane, 3'b000};

  always_comb begin
    be = 4'hF;
    wd = '0;
    case (op_q)
      EXE_SB_OP: begin be = 4'b0001 << lane;  wd = {4{wdata_q[7:0]}};  end
      EXE_SH_OP: begin be = 4'b0011 << hlane; wd = {2{wdata_q[15:0]}}; end
      EXE_SW_OP, EXE_SC_OP: wd = wdata_q;
      EXE_SWL_OP: begin
        case (lane)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0011;
          2'd2:    be = 4'b0111;
          default: be = 4'b1111;
        endcase
        wd = wdata_q >> sh_r;
      end
      EXE_SWR_OP: begin be = 4'b1111 << lane; wd = wdata_q << sh_l; end
      EXE_LB_OP, EXE_LBU_OP: be = 4'b0001 << lane;
      EXE_LH_OP, EXE_LHU_OP: be = 4'b0011 << hlane;
      default: be = 4'hF;
    endcase
  end

  assign byte_sel = 8'(word_q >> sh_l);
  assign half_sel = 16'(word_q >> {hlane, 3'b000});

  always_comb begin
    res = '0;
    case (op_q)
      EXE_LB_OP:             res = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP:            res = {24'd0, byte_sel};
      EXE_LH_OP:             res = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP:            res = {16'd0, half_sel};
      EXE_LW_OP, EXE_LL_OP:  res = word_q;
      EXE_LWL_OP:            res = (word_q << sh_r) | (wdata_q & ~(32'hFFFFFFFF << sh_r));
      EXE_LWR_OP:            res = (word_q >> sh_l) | (wdata_q & ~(32'hFFFFFFFF >> sh_l));
      EXE_SC_OP:             res = {31'd0, !scfail_q};
      default:               res = '0;
    endcase
  end

  // llclr_i is applied last so it wins over a coincident LL completion.
  always_comb begin
    llbit_d = llbit_q;
    if (done_o && !exc_any) begin
      if (op_q == EXE_LL_OP)      llbit_d = 1'b1;
      else if (op_q == EXE_SC_OP) llbit_d = 1'b0;
    end
    if (llclr_i) llbit_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
      berr_q    <= 1'b0;
      scfail_q  <= 1'b0;
      flushed_q <= 1'b0;
      llbit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      adel_q    <= adel_d;
      ades_q    <= ades_d;
      berr_q    <= berr_d;
      scfail_q  <= scfail_d;
      flushed_q <= flushed_d;
      llbit_q   <= llbit_d;
    end
  end

  assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign done_o      = (state_q == S_DONE) && !flush_i;
  assign adel_o      = done_o && adel_q;
  assign ades_o      = done_o && ades_q;
  assign buserr_o    = done_o && berr_q;
  assign rdata_o     = (done_o && !exc_any) ? res : 32'd0;
  assign llbit_o     = llbit_q;
  assign bus_req_o   = in_req;
  assign bus_we_o    = in_req && is_store(op_q);
  assign bus_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_o    = in_req ? be : 4'h0;
  assign bus_wdata_o = in_req ? wd : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (little-endian, TIMEOUT_CYC=4).
module tb_mem_access_unit;

  localparam logic [7:0] LB  = 8'b11100000;
  localparam logic [7:0] LBU = 8'b11100100;
  localparam logic [7:0] LH  = 8'b11100001;
  localparam logic [7:0] LHU = 8'b11100101;
  localparam logic [7:0] LW  = 8'b11100011;
  localparam logic [7:0] LWL = 8'b11100010;
  localparam logic [7:0] LWR = 8'b11100110;
  localparam logic [7:0] SB  = 8'b11101000;
  localparam logic [7:0] SH  = 8'b11101001;
  localparam logic [7:0] SW  = 8'b11101011;
  localparam logic [7:0] SWL = 8'b11101010;
  localparam logic [7:0] SWR = 8'b11101110;
  localparam logic [7:0] LL  = 8'b11110000;
  localparam logic [7:0] SC  = 8'b11111000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_i = 1'b0, flush_i = 1'b0, llclr_i = 1'b0;
  logic [7:0]  op_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        stall_o, done_o, adel_o, ades_o, buserr_o, llbit_o;
  logic [31:0] rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(4), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .llclr_i(llclr_i), .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .adel_o(adel_o), .ades_o(ades_o), .buserr_o(buserr_o), .llbit_o(llbit_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  exc;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0, n_err = 0, n_done = 0, cyc_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    if (!rst && done_o) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rdata", rdata_o, e.rdata);
        check_eq("exc", {29'd0, adel_o, ades_o, buserr_o}, {29'd0, e.exc});
        check_eq("done_cyc", cyc_cnt, e.cyc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_st(input logic [7:0] op);
    return op inside {SB, SH, SW, SWL, SWR, SC};
  endfunction

  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] word, input logic [31:0] exp_r, input logic [2:0] exp_exc,
                       input logic exp_bus, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input int ack_dly);
    exp_t e;
    int   n0;
    n0 = n_done;
    e.rdata = exp_r;
    e.exc   = exp_exc;
    e.cyc   = cyc_cnt + (exp_bus ? 3 + ack_dly : 1);
    sb_q.push_back(e);
    op_i = op; addr_i = addr; wdata_i = wd; req_i = 1'b1;
    cyc();
    req_i = 1'b0;
    check_eq("stall_accept", stall_o, exp_bus);
    check_eq("bus_req", bus_req_o, exp_bus);
    if (exp_bus) begin
      check_eq("bus_be", bus_be_o, exp_be);
      check_eq("bus_we", bus_we_o, is_st(op));
      check_eq("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
      if (is_st(op)) check_eq("bus_wdata", bus_wdata_o, exp_wd);
      bus_gnt_i = 1'b1;
      cyc();
      bus_gnt_i = 1'b0;
      check_eq("req_dropped", bus_req_o, 1'b0);
      for (int i = 0; i < ack_dly; i++) begin
        check_eq("stall_wait", stall_o, 1'b1);
        cyc();
      end
      check_eq("stall_wait", stall_o, 1'b1);
      bus_ack_i = 1'b1; bus_rdata_i = word;
      cyc();
      bus_ack_i = 1'b0;
    end
    check_eq("stall_done", stall_o, 1'b0);
    cyc();
    check_eq("done_count", n_done, n0 + 1);
  endtask

  initial begin
    int   n0;
    exp_t e;
    #1;
    check_eq("rst_stall", stall_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_busreq", bus_req_o, 1'b0);
    check_eq("rst_llbit", llbit_o, 1'b0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_be", bus_be_o, 4'h0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    do_op(LW,  32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 1'b1, 4'hF, 32'h0, 1);
    do_op(LW,  32'h104, 32'h0, 32'h12345678, 32'h12345678, 3'b000, 1'b1, 4'hF, 32'h0, 0);
    do_op(LB,  32'h103, 32'h0, 32'h80112233, 32'hFFFFFF80, 3'b000, 1'b1, 4'b1000, 32'h0, 0);
    do_op(LBU, 32'h103, 32'h0, 32'h80112233, 32'h00000080, 3'b000, 1'b1, 4'b1000, 32'h0, 0);
    do_op(LH,  32'h102, 32'h0, 32'h80112233, 32'hFFFF8011, 3'b000, 1'b1, 4'b1100, 32'h0, 0);
    do_op(LHU, 32'h100, 32'h0, 32'h80118233, 32'h00008233, 3'b000, 1'b1, 4'b0011, 32'h0, 0);
    do_op(LH,  32'h101, 32'h0, 32'h0, 32'h0, 3'b100, 1'b0, 4'h0, 32'h0, 0);
    do_op(SW,  32'h102, 32'h1, 32'h0, 32'h0, 3'b010, 1'b0, 4'h0, 32'h0, 0);
    do_op(SB,  32'h102, 32'h000000A5, 32'h0, 32'h0, 3'b000, 1'b1, 4'b0100, 32'hA5A5A5A5, 0);
    do_op(SH,  32'h102, 32'h00001234, 32'h0, 32'h0, 3'b000, 1'b1, 4'b1100, 32'h12341234, 0);

    do_op(LL,  32'h200, 32'h0, 32'h00000055, 32'h00000055, 3'b000, 1'b1, 4'hF, 32'h0, 0);
    check_eq("llbit_after_ll", llbit_o, 1'b1);
    do_op(SC,  32'h200, 32'h5, 32'h0, 32'h1, 3'b000, 1'b1, 4'hF, 32'h5, 0);
    check_eq("llbit_after_sc", llbit_o, 1'b0);
    do_op(SC,  32'h200, 32'h5, 32'h0, 32'h0, 3'b000, 1'b0, 4'h0, 32'h0, 0);

    do_op(SWR, 32'h301, 32'hAABBCCDD, 32'h0, 32'h0, 3'b000, 1'b1, 4'b1110, 32'hBBCCDD00, 0);
    do_op(SWL, 32'h301, 32'hAABBCCDD, 32'h0, 32'h0, 3'b000, 1'b1, 4'b0011, 32'h0000AABB, 0);
    do_op(LWL, 32'h301, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD, 3'b000, 1'b1, 4'hF, 32'h0, 0);
    do_op(LWR, 32'h301, 32'hAABBCCDD, 32'h11223344, 32'hAA112233, 3'b000, 1'b1, 4'hF, 32'h0, 0);

    // gnt never comes: four REQ cycles, then buserr
    n0 = n_done;
    e.rdata = 32'h0; e.exc = 3'b001; e.cyc = cyc_cnt + 5;
    sb_q.push_back(e);
    op_i = LW; addr_i = 32'h400; req_i = 1'b1;
    cyc();
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("tmo_req_held", bus_req_o, 1'b1);
      cyc();
    end
    check_eq("tmo_req_dropped", bus_req_o, 1'b0);
    cyc();
    check_eq("tmo_done_count", n_done, n0 + 1);

    // flush in REQ before gnt
    n0 = n_done;
    op_i = LW; addr_i = 32'h404; req_i = 1'b1;
    cyc();
    req_i = 1'b0;
    check_eq("flreq_req", bus_req_o, 1'b1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check_eq("flreq_busreq", bus_req_o, 1'b0);
    check_eq("flreq_stall", stall_o, 1'b0);
    cyc(); cyc();
    check_eq("flreq_no_done", n_done, n0);

    // LL flushed in WAIT: ack still awaited, no done, LLbit untouched
    op_i = LL; addr_i = 32'h500; req_i = 1'b1;
    cyc();
    req_i = 1'b0;
    bus_gnt_i = 1'b1;
    cyc();
    bus_gnt_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check_eq("flwait_stall_held", stall_o, 1'b1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h77;
    cyc();
    bus_ack_i = 1'b0;
    check_eq("flwait_stall", stall_o, 1'b0);
    cyc(); cyc();
    check_eq("flwait_no_done", n_done, n0);
    check_eq("flwait_llbit", llbit_o, 1'b0);

    do_op(LL, 32'h600, 32'h0, 32'h99, 32'h99, 3'b000, 1'b1, 4'hF, 32'h0, 0);
    check_eq("llbit_set2", llbit_o, 1'b1);
    llclr_i = 1'b1;
    cyc();
    llclr_i = 1'b0;
    check_eq("llclr", llbit_o, 1'b0);

    // async reset in WAIT
    do_op(LL, 32'h600, 32'h0, 32'h99, 32'h99, 3'b000, 1'b1, 4'hF, 32'h0, 0);
    op_i = LW; addr_i = 32'h700; req_i = 1'b1;
    cyc();
    req_i = 1'b0;
    bus_gnt_i = 1'b1;
    cyc();
    bus_gnt_i = 1'b0;
    check_eq("pre_rst_stall", stall_o, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_stall", stall_o, 1'b0);
    check_eq("rst_mid_llbit", llbit_o, 1'b0);
    check_eq("rst_mid_busreq", bus_req_o, 1'b0);
    check_eq("rst_mid_done", done_o, 1'b0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
